// File: rtl/data_acquire_avg.sv
// ============================================================================
// Module   : data_acquire_avg
// Purpose  : Burst-averaging ADC acquirer; optional min/max via DATA_ACQUIRE_MINMAX_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module data_acquire_avg #(
    parameter int DATA_W  = 12,
    parameter int LOG2_N  = 3,
    parameter int SIGNED  = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    output logic              adc_data_req_o,
    input  logic              adc_data_rdy_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              syncro_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_rdy_o,
    output logic              busy_o,
    output logic              err_o,
    output logic              overrun_o
`ifdef DATA_ACQUIRE_MINMAX_EN
    ,
    output logic [DATA_W-1:0] min_o,
    output logic [DATA_W-1:0] max_o
`endif
);

    localparam int c_acc_w = DATA_W + LOG2_N;
    localparam int c_tmo_w = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_acc_w-1:0]   acc_q, acc_d;
    logic [LOG2_N-1:0]    cnt_q, cnt_d;
    logic [c_tmo_w-1:0]   tmo_q, tmo_d;
    logic                 syncro_prev_q, rdy_prev_q;
    logic                 req_q, req_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 data_rdy_q, data_rdy_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 overrun_q, overrun_d;

    logic                 w_syncro_edge, w_rdy_edge;
    logic [c_acc_w-1:0]   w_sample_ext, w_sum;

    assign w_syncro_edge = syncro_i & ~syncro_prev_q;
    assign w_rdy_edge    = adc_data_rdy_i & ~rdy_prev_q;
    assign w_sample_ext  = {{LOG2_N{(SIGNED != 0) & adc_data_i[DATA_W-1]}}, adc_data_i};
    assign w_sum         = acc_q + w_sample_ext;

`ifdef DATA_ACQUIRE_MINMAX_EN
    logic [DATA_W-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;

    function automatic logic less(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) return $signed(a) < $signed(b);
        else             return a < b;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        overrun_d = overrun_q;
`ifdef DATA_ACQUIRE_MINMAX_EN
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        min_d     = min_q;
        max_d     = max_q;
`endif
        // Triggers outside IDLE (including the DONE/ABORT cycle) are dropped.
        if (w_syncro_edge && state_q != S_IDLE) overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (w_syncro_edge) begin
                    state_d   = S_REQ;
                    acc_d     = '0;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (w_rdy_edge) begin
                    acc_d = w_sum;
`ifdef DATA_ACQUIRE_MINMAX_EN
                    run_min_d = (cnt_q == '0 || less(adc_data_i, run_min_q)) ? adc_data_i : run_min_q;
                    run_max_d = (cnt_q == '0 || less(run_max_q, adc_data_i)) ? adc_data_i : run_max_q;
`endif
                    if (&cnt_q) begin
                        state_d = S_DONE;
                        // Low DATA_W bits of the shifted sum are identical for >> and >>>.
                        data_d  = w_sum[c_acc_w-1:LOG2_N];
`ifdef DATA_ACQUIRE_MINMAX_EN
                        min_d   = run_min_d;
                        max_d   = run_max_d;
`endif
                    end else begin
                        cnt_d   = cnt_q + LOG2_N'(1);
                        state_d = S_REQ;
                    end
                end else begin
                    tmo_d = tmo_q + c_tmo_w'(1);
                    if (tmo_d == c_tmo_w'(TIMEOUT)) state_d = S_ABORT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_d      = (state_d == S_REQ);
        data_rdy_d = (state_d == S_DONE);
        err_d      = (state_d == S_ABORT);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            syncro_prev_q <= 1'b0;
            rdy_prev_q    <= 1'b0;
            req_q         <= 1'b0;
            data_q        <= '0;
            data_rdy_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef DATA_ACQUIRE_MINMAX_EN
            run_min_q     <= '0;
            run_max_q     <= '0;
            min_q         <= '0;
            max_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            syncro_prev_q <= syncro_i;
            rdy_prev_q    <= adc_data_rdy_i;
            req_q         <= req_d;
            data_q        <= data_d;
            data_rdy_q    <= data_rdy_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            overrun_q     <= overrun_d;
`ifdef DATA_ACQUIRE_MINMAX_EN
            run_min_q     <= run_min_d;
            run_max_q     <= run_max_d;
            min_q         <= min_d;
            max_q         <= max_d;
`endif
        end
    end

    assign adc_data_req_o = req_q;
    assign data_o         = data_q;
    assign data_rdy_o     = data_rdy_q;
    assign busy_o         = busy_q;
    assign err_o          = err_q;
    assign overrun_o      = overrun_q;
`ifdef DATA_ACQUIRE_MINMAX_EN
    assign min_o          = min_q;
    assign max_o          = max_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_acquire_avg.sv
// Bench for data_acquire_avg: unsigned and signed instances share one stimulus stream.
`default_nettype none
`timescale 1ns/1ps

module tb_data_acquire_avg;

    localparam int DATA_W = 12;
    localparam int LOG2_N = 3;
    localparam int N      = 8;
    localparam int TMO    = 50;

    typedef logic [DATA_W-1:0] burst_t [N];

    logic              clk = 1'b0;
    logic              reset_n, rdy, syncro;
    logic [DATA_W-1:0] din;
    logic              req_u, data_rdy_u, busy_u, err_u, ovr_u;
    logic              req_s, data_rdy_s, busy_s, err_s, ovr_s;
    logic [DATA_W-1:0] data_u, data_s;
`ifdef DATA_ACQUIRE_MINMAX_EN
    logic [DATA_W-1:0] min_u, max_u, min_s, max_s;
`endif

    int checks = 0, errors = 0;
    int req_cnt_u = 0, rdy_cnt_u = 0, rdy_cnt_s = 0;
    int syncro_hold = 0;
    bit exp_ovr = 1'b0;

    data_acquire_avg #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .SIGNED(0), .TIMEOUT(TMO)) dut_u (
        .clk_i(clk), .reset_n_i(reset_n), .adc_data_req_o(req_u), .adc_data_rdy_i(rdy),
        .adc_data_i(din), .syncro_i(syncro), .data_o(data_u), .data_rdy_o(data_rdy_u),
        .busy_o(busy_u), .err_o(err_u), .overrun_o(ovr_u)
`ifdef DATA_ACQUIRE_MINMAX_EN
        , .min_o(min_u), .max_o(max_u)
`endif
    );

    data_acquire_avg #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .SIGNED(1), .TIMEOUT(TMO)) dut_s (
        .clk_i(clk), .reset_n_i(reset_n), .adc_data_req_o(req_s), .adc_data_rdy_i(rdy),
        .adc_data_i(din), .syncro_i(syncro), .data_o(data_s), .data_rdy_o(data_rdy_s),
        .busy_o(busy_s), .err_o(err_s), .overrun_o(ovr_s)
`ifdef DATA_ACQUIRE_MINMAX_EN
        , .min_o(min_s), .max_o(max_s)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (req_u)      req_cnt_u++;
        if (data_rdy_u) rdy_cnt_u++;
        if (data_rdy_s) rdy_cnt_s++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: plain integer arithmetic over the burst.
    function automatic int sval(input logic [DATA_W-1:0] x, input bit sgn);
        return (sgn && x[DATA_W-1]) ? int'(x) - (1 << DATA_W) : int'(x);
    endfunction

    function automatic logic [DATA_W-1:0] mean_ref(input burst_t s, input bit sgn);
        int sum = 0;
        int q;
        for (int i = 0; i < N; i++) sum += sval(s[i], sgn);
        q = sum / N;
        if (sum % N != 0 && sum < 0) q--;
        return DATA_W'(q);
    endfunction

`ifdef DATA_ACQUIRE_MINMAX_EN
    function automatic logic [DATA_W-1:0] ext_ref(input burst_t s, input bit sgn, input bit want_max);
        int b = sval(s[0], sgn);
        for (int i = 1; i < N; i++) begin
            int v = sval(s[i], sgn);
            if (want_max ? (v > b) : (v < b)) b = v;
        end
        return DATA_W'(b);
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (syncro_hold > 0) begin
            syncro_hold--;
            if (syncro_hold == 0) syncro = 1'b0;
        end
    endtask

    task automatic wait_req(input string name, output bit ok);
        int n = 0;
        while (!req_u && n < 100) begin
            tick();
            n++;
        end
        ok = req_u;
        if (ok) check($sformatf("%s req_s", name), req_s, 1);
    endtask

    task automatic run_burst(input string name, input burst_t smp, input int hold,
                             input int repulse_at, input int silent_from, input int reset_after);
        int r0, du0, ds0;
        logic [DATA_W-1:0] prev_u, prev_s;
        bit ok;
        r0 = req_cnt_u; du0 = rdy_cnt_u; ds0 = rdy_cnt_s;
        prev_u = data_u; prev_s = data_s;
        syncro = 1'b1; syncro_hold = hold; exp_ovr = 1'b0;
        for (int i = 0; i < N; i++) begin
            wait_req(name, ok);
            if (!ok) begin
                check($sformatf("%s req%0d timeout", name, i), 0, 1);
                return;
            end
            if (i == 0) begin
                check($sformatf("%s busy", name), busy_u, 1);
                check($sformatf("%s ovr_clr", name), ovr_u, 0);
            end
            if (i == silent_from) begin
                repeat (TMO) tick();
                check($sformatf("%s err_early", name), {err_u, err_s}, 0);
                tick();
                check($sformatf("%s err", name), {err_u, err_s}, 2'b11);
                check($sformatf("%s abort_rdy", name), {data_rdy_u, data_rdy_s}, 0);
                check($sformatf("%s data_held_u", name), data_u, prev_u);
                check($sformatf("%s data_held_s", name), data_s, prev_s);
                check($sformatf("%s abort_busy", name), busy_u, 1);
                tick();
                check($sformatf("%s idle_busy", name), {busy_u, busy_s, err_u}, 0);
                check($sformatf("%s req_count", name), req_cnt_u - r0, silent_from + 1);
                check($sformatf("%s rdy_count", name), rdy_cnt_u - du0 + rdy_cnt_s - ds0, 0);
                return;
            end
            repeat ($urandom_range(1, 5)) tick();
            rdy = 1'b1;
            din = smp[i];
            if (i == repulse_at) begin
                syncro = 1'b1; syncro_hold = 1; exp_ovr = 1'b1;
            end
            tick();
            rdy = 1'b0;
            din = DATA_W'($urandom);
            if (i == reset_after) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
                check($sformatf("%s rst_ctl_u", name), {req_u, data_rdy_u, busy_u, err_u, ovr_u}, 0);
                check($sformatf("%s rst_ctl_s", name), {req_s, data_rdy_s, busy_s, err_s, ovr_s}, 0);
                check($sformatf("%s rst_data", name), {data_u, data_s}, 0);
                repeat (3) tick();
                check($sformatf("%s rst_silent", name), rdy_cnt_u - du0 + rdy_cnt_s - ds0, 0);
                return;
            end
        end
        check($sformatf("%s data_rdy", name), {data_rdy_u, data_rdy_s}, 2'b11);
        check($sformatf("%s data_u", name), data_u, mean_ref(smp, 1'b0));
        check($sformatf("%s data_s", name), data_s, mean_ref(smp, 1'b1));
        check($sformatf("%s err_done", name), {err_u, err_s}, 0);
        check($sformatf("%s overrun", name), {ovr_u, ovr_s}, {exp_ovr, exp_ovr});
`ifdef DATA_ACQUIRE_MINMAX_EN
        check($sformatf("%s min_u", name), min_u, ext_ref(smp, 1'b0, 1'b0));
        check($sformatf("%s max_u", name), max_u, ext_ref(smp, 1'b0, 1'b1));
        check($sformatf("%s min_s", name), min_s, ext_ref(smp, 1'b1, 1'b0));
        check($sformatf("%s max_s", name), max_s, ext_ref(smp, 1'b1, 1'b1));
`endif
        tick();
        tick();
        check($sformatf("%s busy_end", name), {busy_u, busy_s}, 0);
        check($sformatf("%s req_count", name), req_cnt_u - r0, N);
        check($sformatf("%s rdy_pulses", name), {rdy_cnt_u - du0, rdy_cnt_s - ds0}, {32'd1, 32'd1});
    endtask

    initial begin
        burst_t b;
        reset_n = 1'b0; rdy = 1'b0; syncro = 1'b0; din = '0;
        repeat (3) tick();
        check("reset ctl_u", {req_u, data_rdy_u, busy_u, err_u, ovr_u}, 0);
        check("reset ctl_s", {req_s, data_rdy_s, busy_s, err_s, ovr_s}, 0);
        check("reset data", {data_u, data_s}, 0);
        reset_n = 1'b1;
        tick();

        b = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
        run_burst("ramp", b, 1, -1, N, -1);
        check("ramp mean", data_u, 12'd4);

        foreach (b[i]) b[i] = 12'hFFF;
        run_burst("full", b, 1, -1, N, -1);

        b = '{12'd92, 12'd65, 12'd4, 12'd222, 12'd0, 12'd4019, 12'd12, 12'd3};
        run_burst("mixed", b, 1, -1, N, -1);
        check("mixed mean_u", data_u, 12'd552);
        check("mixed mean_s", data_s, 12'd40);

        b = '{12'd3, 12'd12, 12'd4019, 12'd0, 12'd222, 12'd4, 12'd65, 12'd92};
        run_burst("minmax", b, 1, -1, N, -1);

        b = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
        run_burst("overrun", b, 5, 4, N, -1);

        foreach (b[i]) b[i] = DATA_W'($urandom);
        run_burst("reset", b, 1, 2, N, 4);

        foreach (b[i]) b[i] = 12'd10;
        run_burst("post_reset", b, 1, -1, N, -1);
        check("post_reset mean", data_u, 12'd10);

        foreach (b[i]) b[i] = DATA_W'($urandom);
        run_burst("timeout", b, 1, -1, 3, -1);

        for (int r = 0; r < 6; r++) begin
            foreach (b[i]) b[i] = DATA_W'($urandom);
            run_burst($sformatf("rand%0d", r), b, 1, -1, N, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_acquire_avg.md
Name: data_acquire_avg

Overview:
Parametrised successor of the single-channel burst-averaging acquirer.
- A rising edge on syncro_i starts one burst of 2**LOG2_N ADC conversions over the req/rdy handshake.
- The samples are accumulated at full width; the mean is returned on data_o with a one-cycle data_rdy_o strobe.
- Adds configurable width, depth, signed mode, a per-sample handshake timeout, and a trigger-overrun flag.
- Sits between the ADC driver and the processing/diagnostic logic.

Parameters:
DATA_W, 12, ADC sample and result width (bits).
LOG2_N, 3, log2 of samples per burst (1..8); burst length N = 2**LOG2_N.
SIGNED, 0, 1 = samples are two's complement, sign-extended and arithmetic-shifted; 0 = unsigned.
TIMEOUT, 1023, max clk cycles to wait for adc_data_rdy_i rising edge per sample (>= 2).

Ports:
clk_i  in  1  system clock; all logic on rising edge.
reset_n_i  in  1  reset, synchronous, active-low.
adc_data_req_o  out  1  one-cycle conversion request to ADC.
adc_data_rdy_i  in  1  ADC data valid; a rising edge marks a new sample.
adc_data_i  in  DATA_W  ADC sample, valid on the rdy rising-edge cycle.
syncro_i  in  1  acquisition trigger (level; rising edge used).
data_o  out  DATA_W  burst mean; held until the next result.
data_rdy_o  out  1  one-cycle strobe, data_o valid.
busy_o  out  1  high from trigger accept until the DONE/ABORT state exits.
err_o  out  1  one-cycle strobe on timeout abort.
overrun_o  out  1  sticky; set by a syncro_i rising edge while busy; cleared on next accepted trigger.

Behaviour:
- Reset (reset_n_i low at a clk edge): all outputs 0, accumulator/counters 0, FSM to IDLE, edge-detect registers 0. Reset mid-burst aborts silently: no data_rdy_o, no err_o.
- Edge detection: registered previous values of syncro_i and adc_data_rdy_i; edge = current & ~previous. Edge registers update in every state.
- FSM IDLE: on syncro edge -> REQ; clear acc, sample count, overrun_o; busy_o=1.
- FSM REQ: adc_data_req_o=1 for exactly this cycle; clear timeout counter; -> WAIT.
- FSM WAIT: a rdy edge captures adc_data_i and adds it to acc.
  - If count == N-1 -> DONE; else count+1 -> REQ.
  - Timeout counter increments each WAIT cycle without an edge; reaching TIMEOUT -> ABORT.
  - A rdy edge in the same cycle the counter reaches TIMEOUT is accepted (sample wins).
- FSM DONE: data_o <= acc >>> LOG2_N (SIGNED=1) or acc >> LOG2_N (SIGNED=0); low DATA_W bits kept; data_rdy_o=1; -> IDLE.
- FSM ABORT: err_o=1; data_o unchanged; -> IDLE.
- Accumulator: width DATA_W+LOG2_N. Samples are sign- or zero-extended to that width before adding, so no overflow is possible.
- Rounding: truncation, i.e. floor (toward -inf in signed mode).
- Latency: data_rdy_o is asserted 1 cycle after the cycle in which the last rdy edge is seen.
- Triggers:
  - syncro edges while busy are ignored and set overrun_o.
  - A syncro edge in the same cycle as DONE/ABORT is also ignored (sets overrun_o).
  - A new trigger is accepted only from IDLE.
- adc_data_rdy_i already high in REQ: no edge, so the block waits for the ADC to drop and re-raise rdy.

Optional Feature:
Macro DATA_ACQUIRE_MINMAX_EN.
- Defined: extra ports min_o, max_o (DATA_W, out; reset 0), compared per SIGNED. Running min/max are initialised from the first sample of the burst and updated on each accepted sample. They are published together with data_o on the data_rdy_o cycle and unchanged on abort.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
1. DATA_W=12, LOG2_N=3, SIGNED=0; trigger, samples 1,2,...,8 -> one data_rdy_o pulse, data_o=4, err_o=0, 8 adc_data_req_o pulses.
2. SIGNED=0, samples all 4095 -> data_o=4095.
   - Samples 92,65,4,222,0,4019,12,3 -> data_o=552.
   - Same bits with SIGNED=1 (4019 = -77) -> data_o=40.
   - SIGNED=1, all 0xFFF -> data_o=0xFFF (-1).
3. Timeout: TIMEOUT=50; ADC answers samples 0..2 then stays silent -> err_o pulse exactly 50 WAIT cycles after the 4th req; no data_rdy_o; data_o keeps its previous value; busy_o=0 next cycle.
4. syncro_i held high 5 cycles, then re-pulsed mid-burst -> a single burst of 8 reqs; overrun_o=1 after the re-pulse; overrun_o cleared by the next accepted trigger.
5. reset_n_i low for 1 cycle after the 5th sample -> all outputs 0. A new trigger then yields a correct mean of fresh samples 10,...,10 -> data_o=10.
6. MINMAX_EN defined, samples 3,12,-77,0,222,4,65,92, SIGNED=1 -> min_o=-77, max_o=222, data_o=40.
